// File: rtl/uart_rx_fifo_pkg.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo_pkg
//   Shared UART receive-path definitions for the receive byte FIFO and its
//   storage array.
//   - UART_DATA_W        : width of one received UART byte.
//   - FIFO_DEPTH_LOG2    : default log2 depth of the receive FIFO (16 entries).
//   - fifo_op_t          : per-cycle decoded FIFO operation. The top level
//                          builds it from its inputs and state, and the update
//                          logic uses it.
// -----------------------------------------------------------------------------
package uart_rx_fifo_pkg;

  localparam int UART_DATA_W     = 8;
  localparam int FIFO_DEPTH_LOG2 = 4;

  // Decoded operation for the current cycle.
  typedef struct packed {
    logic push;    // first cycle of a done pulse
    logic pop;     // consumer read of a non-empty FIFO
    logic accept;  // push that is written into storage
    logic drop;    // push lost because the FIFO is full and nothing pops
  } fifo_op_t;

endpackage : uart_rx_fifo_pkg

// File: rtl/uart_rx_fifo_mem.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo_mem
//   Storage array for the UART receive FIFO. It holds 2**DEPTH_LOG2 words of
//   DATA_W bits. Writes are synchronous. The read port is asynchronous, which
//   suits a distributed-RAM implementation and gives the FIFO its
//   first-word-fall-through behaviour.
// Ports
//   CLK      in   clock
//   wr_en    in   write strobe
//   wr_addr  in   write address (DEPTH_LOG2 bits)
//   wr_data  in   write data (DATA_W bits)
//   rd_addr  in   read address (DEPTH_LOG2 bits)
//   rd_data  out  combinational read data, mem[rd_addr]
// -----------------------------------------------------------------------------
module uart_rx_fifo_mem
  import uart_rx_fifo_pkg::*;
#(
  parameter int DATA_W     = UART_DATA_W,
  parameter int DEPTH_LOG2 = FIFO_DEPTH_LOG2
) (
  input  logic                  CLK,
  input  logic                  wr_en,
  input  logic [DEPTH_LOG2-1:0] wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [DEPTH_LOG2-1:0] rd_addr,
  output logic [DATA_W-1:0]     rd_data
);

  logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

  // NOTE: the array has no reset. Resetting a RAM turns it into a large bank
  //       of flops. The FIFO only reads entries it has already written, so the
  //       contents after reset do not matter.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule : uart_rx_fifo_mem

// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
//   Byte buffer that sits directly after the UART receiver. It captures one
//   byte on each rising edge of rx_done. It holds up to 2**DEPTH_LOG2 bytes and
//   presents them first-word-fall-through. Any byte that arrives while the
//   FIFO is full and nothing is popped is dropped, and a sticky flag records
//   the drop.
// Optional feature
//   `define UART_RX_FIFO_DROP_CNT_EN adds output drop_cnt[7:0]. This is a
//   saturating count of dropped bytes, cleared by clr_overflow.
// Ports
//   CLK           in   system clock
//   reset         in   asynchronous, active-high reset
//   rx_done       in   receiver done level (may stay high several cycles)
//   rx_data       in   received byte, stable while rx_done is high
//   rd_en         in   consumer pop request (ignored when empty)
//   rd_data       out  head entry, valid whenever empty is 0
//   empty         out  no entries stored
//   full          out  count equals 2**DEPTH_LOG2
//   count         out  number of stored entries (DEPTH_LOG2+1 bits)
//   overflow      out  sticky, at least one byte dropped
//   drop_cnt      out  dropped-byte count (only with the macro defined)
//   clr_overflow  in   clears overflow (and drop_cnt)
// -----------------------------------------------------------------------------
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int DATA_W     = UART_DATA_W,
  parameter int DEPTH_LOG2 = FIFO_DEPTH_LOG2
) (
  input  logic                  CLK,
  input  logic                  reset,
  input  logic                  rx_done,
  input  logic [DATA_W-1:0]     rx_data,
  input  logic                  rd_en,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
`ifdef UART_RX_FIFO_DROP_CNT_EN
  output logic [7:0]            drop_cnt,
`endif
  input  logic                  clr_overflow
);

  localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic                  done_q;
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  fifo_op_t              op;

  // Flags come from count, not from a pointer compare. With a power-of-two
  // depth the pointers are equal both when the FIFO is empty and when it is
  // full, so a pointer compare cannot tell the two apart.
  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);

  // NOTE: every signal written in always_comb gets a default value first.
  //       Otherwise any path that misses an assignment infers a latch.
  always_comb begin
    op        = '0;
    op.push   = rx_done & ~done_q;
    op.pop    = rd_en & ~empty;
    // When the FIFO is full, a push is accepted only if a pop frees a slot in
    // the same cycle.
    op.accept = op.push & (~full | op.pop);
    op.drop   = op.push & full & ~op.pop;
  end

  // NOTE: sequential state uses non-blocking assignments only. All flops then
  //       sample values from before the clock edge, whatever order the
  //       processes run in.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      done_q <= 1'b0;
    end else begin
      done_q <= rx_done;
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Pointers are DEPTH_LOG2 bits wide and wrap modulo the depth.
      if (op.accept) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (op.pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({op.accept, op.pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky drop flag. A drop in the same cycle as a clear wins, so the drop
  // is not lost.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (op.drop) begin
      overflow <= 1'b1;
    end else if (clr_overflow) begin
      overflow <= 1'b0;
    end
  end

`ifdef UART_RX_FIFO_DROP_CNT_EN
  // Saturating drop counter. A drop in the same cycle as a clear restarts the
  // count at 1.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      drop_cnt <= '0;
    end else if (clr_overflow) begin
      drop_cnt <= op.drop ? 8'd1 : 8'd0;
    end else if (op.drop && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end
`endif

  uart_rx_fifo_mem #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_mem (
    .CLK     (CLK),
    .wr_en   (op.accept),
    .wr_addr (wr_ptr),
    .wr_data (rx_data),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

endmodule : uart_rx_fifo

// File: tb/tb_uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_fifo
//   Directed self-checking bench for uart_rx_fifo (DATA_W=8, DEPTH_LOG2=4).
//   Inputs change and outputs are sampled 1 ns after each rising edge.
//   Defining UART_RX_FIFO_DROP_CNT_EN also checks the drop counter.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_rx_fifo;

  logic       CLK = 1'b0;
  logic       reset;
  logic       rx_done;
  logic [7:0] rx_data;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       empty;
  logic       full;
  logic [4:0] count;
  logic       overflow;
  logic       clr_overflow;
`ifdef UART_RX_FIFO_DROP_CNT_EN
  logic [7:0] drop_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  uart_rx_fifo #(.DATA_W(8), .DEPTH_LOG2(4)) dut (
    .CLK          (CLK),
    .reset        (reset),
    .rx_done      (rx_done),
    .rx_data      (rx_data),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .empty        (empty),
    .full         (full),
    .count        (count),
    .overflow     (overflow),
`ifdef UART_RX_FIFO_DROP_CNT_EN
    .drop_cnt     (drop_cnt),
`endif
    .clr_overflow (clr_overflow)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One rx_done pulse of one cycle, then one cycle low so the next pulse is a
  // new rising edge.
  task automatic push_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
    tick();
  endtask

  task automatic pop_one();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  initial begin
    reset = 1'b1; rx_done = 1'b0; rx_data = 8'h00; rd_en = 1'b0; clr_overflow = 1'b0;
    tick();
    tick();

    // ---- 1: reset state and idle pops ----
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_count", count, 0);
    check("rst_ovf", overflow, 0);
`ifdef UART_RX_FIFO_DROP_CNT_EN
    check("rst_dropcnt", drop_cnt, 0);
`endif
    reset = 1'b0;
    tick();
    rd_en = 1'b1;
    tick();
    tick();
    rd_en = 1'b0;
    check("idle_pop_count", count, 0);
    check("idle_pop_empty", empty, 1);

    // ---- 2: done held 3 cycles -> one push ----
    rx_data = 8'hA5;
    rx_done = 1'b1;
    tick();
    check("t2_data", rd_data, 8'hA5);
    check("t2_count1", count, 1);
    check("t2_empty", empty, 0);
    tick();
    tick();
    check("t2_count_held", count, 1);
    rx_done = 1'b0;
    tick();
    pop_one();
    check("t2_pop_empty", empty, 1);
    check("t2_pop_count", count, 0);

    // ---- 3: fill to full, drop one, drain in order ----
    for (int i = 0; i < 16; i++) push_byte(8'(i));
    check("t3_full", full, 1);
    check("t3_count16", count, 16);
    check("t3_no_ovf", overflow, 0);
    push_byte(8'hFF);
    check("t3_ovf", overflow, 1);
    check("t3_count_after_drop", count, 16);
`ifdef UART_RX_FIFO_DROP_CNT_EN
    check("t3_dropcnt", drop_cnt, 1);
`endif
    for (int i = 0; i < 16; i++) begin
      check($sformatf("t3_drain%0d", i), rd_data, i);
      pop_one();
    end
    check("t3_drained_empty", empty, 1);
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    check("t3_ovf_cleared", overflow, 0);

    // ---- 4: full + push + pop -> nothing dropped, pointer wrap ----
    for (int i = 0; i < 16; i++) push_byte(8'(8'h10 + i));
    check("t4_full", full, 1);
    rx_data = 8'h55;
    rx_done = 1'b1;
    rd_en   = 1'b1;
    tick();
    rx_done = 1'b0;
    rd_en   = 1'b0;
    check("t4_count16", count, 16);
    check("t4_no_ovf", overflow, 0);
    tick();
    for (int i = 0; i < 16; i++) begin
      check($sformatf("t4_drain%0d", i), rd_data, (i < 15) ? (8'h11 + i) : 8'h55);
      pop_one();
    end
    check("t4_drained_empty", empty, 1);

    // ---- 5a: empty + push + pop -> push only ----
    rx_data = 8'h3C;
    rx_done = 1'b1;
    rd_en   = 1'b1;
    tick();
    rx_done = 1'b0;
    rd_en   = 1'b0;
    check("t5_count1", count, 1);
    check("t5_data", rd_data, 8'h3C);
    check("t5_not_empty", empty, 0);
    tick();
    pop_one();

    // ---- 5b: drop in same cycle as clr_overflow -> set wins ----
    for (int i = 0; i < 16; i++) push_byte(8'(8'h20 + i));
    push_byte(8'hEE);
    check("t5_ovf_first_drop", overflow, 1);
    rx_data      = 8'hEF;
    rx_done      = 1'b1;
    clr_overflow = 1'b1;
    tick();
    rx_done      = 1'b0;
    clr_overflow = 1'b0;
    check("t5_ovf_set_wins", overflow, 1);
    check("t5_count16", count, 16);
`ifdef UART_RX_FIFO_DROP_CNT_EN
    check("t5_dropcnt_clr_drop", drop_cnt, 1);
    tick();
    for (int i = 0; i < 260; i++) push_byte(8'hAA);
    check("t5_dropcnt_sat", drop_cnt, 255);
`endif
    tick();
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    check("t5_ovf_clr", overflow, 0);
`ifdef UART_RX_FIFO_DROP_CNT_EN
    check("t5_dropcnt_clr", drop_cnt, 0);
`endif

    // ---- 6: async reset mid-fill ----
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) push_byte(8'(8'h60 + i));
    check("t6_count5", count, 5);
    #2;
    reset = 1'b1;
    #1;
    check("t6_async_count", count, 0);
    check("t6_async_empty", empty, 1);
    check("t6_async_full", full, 0);
    check("t6_async_ovf", overflow, 0);
    #1;
    reset = 1'b0;
    tick();
    push_byte(8'h77);
    check("t6_first_after_rst", rd_data, 8'h77);
    check("t6_count1", count, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_uart_rx_fifo
